// File: rtl/disp_hole_fill.sv
// disp_hole_fill: streaming scanline hole filler ahead of the median filter.
// Optional build macro HOLE_FILL_RUNLIMIT_EN: runs longer than MAX_RUN are zero-filled.
module disp_hole_fill #(
   parameter int               WIDTH   = 9,
   parameter logic [WIDTH-1:0] INVALID = {WIDTH{1'b1}},
   parameter int               MAX_RUN = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clken,
   input  logic             enable,
   input  logic [10:0]      width,
   input  logic [WIDTH-1:0] disp_in,
   input  logic             valid_in,
   output logic             in_ready,
   output logic [WIDTH-1:0] disp_hole,
   output logic             valid_final_hole,
   output logic             flag
);

`ifdef HOLE_FILL_RUNLIMIT_EN
   localparam bit RUN_LIMIT = 1'b1;
`else
   localparam bit RUN_LIMIT = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_PASS    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t           state_r, state_s;
   logic [10:0]      col_r, col_s;
   logic [10:0]      row_width_r, row_width_s;
   logic [10:0]      run_cnt_r, run_cnt_s;
   logic [WIDTH-1:0] left_val_r, left_val_s;
   logic [WIDTH-1:0] term_r, term_s;
   logic [WIDTH-1:0] fill_r, fill_s;
   logic             left_valid_r, left_valid_s;
   logic             term_pending_r, term_pending_s;
   logic             row_end_pend_r, row_end_pend_s;
   logic [WIDTH-1:0] disp_hole_s;
   logic             valid_s;
   logic             flag_s;

   logic             xfer_s;
   logic             row_start_s;
   logic             row_end_s;
   logic             is_hole_s;
   logic             left_ok_s;
   logic [10:0]      eff_width_s;

   function automatic logic [WIDTH-1:0] min_left(input logic [WIDTH-1:0] l,
                                                 input logic [WIDTH-1:0] t);
      if (t < l) min_left = t;
      else       min_left = l;
   endfunction

   function automatic logic [WIDTH-1:0] limit_fill(input logic [10:0]      run,
                                                   input logic [WIDTH-1:0] val);
      if (RUN_LIMIT && (run > 11'(MAX_RUN))) limit_fill = {WIDTH{1'b0}};
      else                                   limit_fill = val;
   endfunction

   assign in_ready    = (state_r != ST_FLUSH);
   assign xfer_s      = clken & valid_in & in_ready;
   assign row_start_s = (col_r == 11'd0);
   // Row width is latched on column 0, but that pixel itself must already see it.
   assign eff_width_s = row_start_s ? width : row_width_r;
   assign row_end_s   = (col_r == (eff_width_s - 11'd1));
   assign is_hole_s   = (disp_in == INVALID);
   assign left_ok_s   = left_valid_r & ~row_start_s;

   // Next-state, column tracking and output selection
   always_comb begin
      state_s        = state_r;
      col_s          = col_r;
      row_width_s    = row_width_r;
      run_cnt_s      = run_cnt_r;
      left_val_s     = left_val_r;
      left_valid_s   = left_valid_r;
      term_s         = term_r;
      term_pending_s = term_pending_r;
      fill_s         = fill_r;
      row_end_pend_s = row_end_pend_r;
      disp_hole_s    = disp_hole;
      valid_s        = 1'b0;
      flag_s         = 1'b0;

      if (xfer_s) begin
         col_s = row_end_s ? 11'd0 : (col_r + 11'd1);
         if (row_start_s) begin
            row_width_s  = width;
            left_valid_s = 1'b0;
         end else begin
            row_width_s  = row_width_r;
         end
      end else begin
         col_s = col_r;
      end

      case (state_r)
         ST_PASS: begin
            if (xfer_s) begin
               if (!enable || !is_hole_s) begin
                  disp_hole_s  = disp_in;
                  valid_s      = 1'b1;
                  flag_s       = row_end_s;
                  left_val_s   = disp_in;
                  left_valid_s = 1'b1;
               end else if (row_end_s) begin
                  run_cnt_s      = 11'd1;
                  term_pending_s = 1'b0;
                  row_end_pend_s = 1'b1;
                  fill_s         = limit_fill(11'd1, left_ok_s ? left_val_r : {WIDTH{1'b0}});
                  state_s        = ST_FLUSH;
               end else begin
                  run_cnt_s = 11'd1;
                  state_s   = ST_COLLECT;
               end
            end else begin
               state_s = ST_PASS;
            end
         end
         ST_COLLECT: begin
            if (xfer_s) begin
               if (!is_hole_s) begin
                  term_s         = disp_in;
                  term_pending_s = 1'b1;
                  row_end_pend_s = row_end_s;
                  fill_s         = limit_fill(run_cnt_r,
                                     left_ok_s ? min_left(left_val_r, disp_in) : disp_in);
                  state_s        = ST_FLUSH;
               end else if (row_end_s) begin
                  run_cnt_s      = run_cnt_r + 11'd1;
                  term_pending_s = 1'b0;
                  row_end_pend_s = 1'b1;
                  fill_s         = limit_fill(run_cnt_r + 11'd1,
                                     left_ok_s ? left_val_r : {WIDTH{1'b0}});
                  state_s        = ST_FLUSH;
               end else begin
                  run_cnt_s = run_cnt_r + 11'd1;
               end
            end else begin
               state_s = ST_COLLECT;
            end
         end
         ST_FLUSH: begin
            if (clken) begin
               valid_s = 1'b1;
               if (run_cnt_r != 11'd0) begin
                  disp_hole_s = fill_r;
                  run_cnt_s   = run_cnt_r - 11'd1;
                  if ((run_cnt_r == 11'd1) && !term_pending_r) begin
                     flag_s  = row_end_pend_r;
                     state_s = ST_PASS;
                  end else begin
                     flag_s  = 1'b0;
                  end
               end else begin
                  // Terminating valid pixel becomes the new left neighbour.
                  disp_hole_s    = term_r;
                  flag_s         = row_end_pend_r;
                  left_val_s     = term_r;
                  left_valid_s   = 1'b1;
                  term_pending_s = 1'b0;
                  state_s        = ST_PASS;
               end
            end else begin
               state_s = ST_FLUSH;
            end
         end
         default: begin
            state_s = ST_PASS;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r          <= ST_PASS;
         col_r            <= 11'd0;
         row_width_r      <= 11'd0;
         run_cnt_r        <= 11'd0;
         left_val_r       <= {WIDTH{1'b0}};
         left_valid_r     <= 1'b0;
         term_r           <= {WIDTH{1'b0}};
         term_pending_r   <= 1'b0;
         fill_r           <= {WIDTH{1'b0}};
         row_end_pend_r   <= 1'b0;
         disp_hole        <= {WIDTH{1'b0}};
         valid_final_hole <= 1'b0;
         flag             <= 1'b0;
      end else begin
         state_r          <= state_s;
         col_r            <= col_s;
         row_width_r      <= row_width_s;
         run_cnt_r        <= run_cnt_s;
         left_val_r       <= left_val_s;
         left_valid_r     <= left_valid_s;
         term_r           <= term_s;
         term_pending_r   <= term_pending_s;
         fill_r           <= fill_s;
         row_end_pend_r   <= row_end_pend_s;
         disp_hole        <= disp_hole_s;
         valid_final_hole <= valid_s;
         flag             <= flag_s;
      end
   end

endmodule

// File: tb/tb_disp_hole_fill.sv
// Scoreboard bench for disp_hole_fill: a row-level reference model pushes expected
// pixels, a negedge monitor pops and compares every output strobe.
`timescale 1ns/1ps
module tb_disp_hole_fill;
   localparam int         W    = 9;
   localparam logic [W-1:0] INV = {W{1'b1}};
   localparam int         MAXR = 2;
`ifdef HOLE_FILL_RUNLIMIT_EN
   localparam bit LIMIT = 1'b1;
`else
   localparam bit LIMIT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         clken;
   logic         enable;
   logic [10:0]  width;
   logic [W-1:0] disp_in;
   logic         valid_in;
   logic         in_ready;
   logic [W-1:0] disp_hole;
   logic         valid_final_hole;
   logic         flag;

   typedef struct packed {
      logic         flg;
      logic [W-1:0] val;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         e;
   logic [W-1:0] row_q[$];
   int           checks = 0;
   int           errors = 0;
   int           busy   = 0;
   bit           rand_ck = 1'b0;
   logic         last_ck = 1'b1;

   // reference model state
   int           m_col = 0;
   int           m_width = 1;
   int           m_holes = 0;
   bit           m_lv = 1'b0;
   logic [W-1:0] m_left = '0;

   disp_hole_fill #(.WIDTH(W), .INVALID(INV), .MAX_RUN(MAXR)) dut (
      .clk(clk), .rst(rst), .clken(clken), .enable(enable), .width(width),
      .disp_in(disp_in), .valid_in(valid_in), .in_ready(in_ready),
      .disp_hole(disp_hole), .valid_final_hole(valid_final_hole), .flag(flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) last_ck <= clken;

   // monitor: every strobe must match the head of the expected queue
   always @(negedge clk) begin
      if (!rst) begin
         if (!last_ck) begin
            checks++;
            if (valid_final_hole) begin
               errors++;
               $display("FAIL clken_hold: valid_final_hole=%0b after clken=0 edge, required 0", valid_final_hole);
            end
         end
         if (valid_final_hole) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_output: got %0d flag %0b, required no output", disp_hole, flag);
            end else begin
               e = exp_q.pop_front();
               if (disp_hole !== e.val || flag !== e.flg) begin
                  errors++;
                  $display("FAIL out_pixel: got %0d flag %0b, required %0d flag %0b",
                           disp_hole, flag, e.val, e.flg);
               end
            end
         end else if (flag) begin
            checks++;
            errors++;
            $display("FAIL flag_alone: flag=1 with valid_final_hole=0, required flag=0");
         end
         if (!in_ready) busy++;
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] fill_of(input int holes, input logic [W-1:0] v);
      if (LIMIT && holes > MAXR) return '0;
      return v;
   endfunction

   // Spec-level model: holes wait until the next valid pixel or the row end.
   task automatic model_accept(input logic [W-1:0] pix);
      bit           last;
      logic [W-1:0] f;
      exp_t         x;
      if (m_col == 0) begin
         m_width = int'(width);
         m_lv    = 1'b0;
         m_holes = 0;
      end
      last = (m_col == m_width - 1);
      if (!enable) begin
         x.val = pix; x.flg = last; exp_q.push_back(x);
      end else if (pix != INV) begin
         f = (m_lv && m_left <= pix) ? m_left : pix;
         f = fill_of(m_holes, f);
         for (int i = 0; i < m_holes; i++) begin
            x.val = f; x.flg = 1'b0; exp_q.push_back(x);
         end
         x.val = pix; x.flg = last; exp_q.push_back(x);
         m_left = pix; m_lv = 1'b1; m_holes = 0;
      end else begin
         m_holes++;
         if (last) begin
            f = fill_of(m_holes, m_lv ? m_left : '0);
            for (int i = 0; i < m_holes; i++) begin
               x.val = f; x.flg = (i == m_holes - 1); exp_q.push_back(x);
            end
            m_holes = 0;
         end
      end
      m_col = last ? 0 : m_col + 1;
   endtask

   task automatic send(input logic [W-1:0] pix);
      bit done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         clken    = rand_ck ? ($urandom_range(0, 3) != 0) : 1'b1;
         disp_in  = pix;
         valid_in = 1'b1;
         #1;
         if (in_ready && clken) begin
            model_accept(pix);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
      chk("send_accepted", int'(done), 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         clken    = rand_ck ? ($urandom_range(0, 3) != 0) : 1'b1;
         valid_in = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic send_row(input int w, input bit rand_w);
      width = 11'(w);
      foreach (row_q[i]) begin
         send(row_q[i]);
         if (i == 0 && rand_w) width = 11'($urandom_range(1, 12));
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 300 && exp_q.size() != 0; n++) idle(1);
      idle(2);
      chk("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      int w;
      rst = 1'b1; clken = 1'b1; enable = 1'b1; width = 11'd4;
      disp_in = '0; valid_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_disp_hole", int'(disp_hole), 0);
      chk("rst_valid", int'(valid_final_hole), 0);
      chk("rst_flag", int'(flag), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // pass-through, no stall
      busy = 0;
      row_q = {9'd5, 9'd6, 9'd7, 9'd8};
      send_row(4, 1'b0); drain();
      chk("pass_busy", busy, 0);

      // interior hole: four flush cycles
      busy = 0;
      row_q = {9'd10, INV, INV, INV, 9'd4, 9'd9};
      send_row(6, 1'b0); drain();
      chk("interior_busy", busy, 4);

      row_q = {INV, INV, 9'd7, 9'd3, INV};
      send_row(5, 1'b0); drain();
      row_q = {INV, INV, INV};
      send_row(3, 1'b0); drain();

      // bypass
      enable = 1'b0;
      row_q = {9'd1, INV, 9'd2};
      send_row(3, 1'b0); drain();
      enable = 1'b1;

      // run limit row and a clken-disturbed flush
      row_q = {9'd8, INV, INV, INV, 9'd9, 9'd9};
      send_row(6, 1'b0); drain();
      rand_ck = 1'b1;
      row_q = {9'd3, INV, INV, INV, INV, 9'd5};
      send_row(6, 1'b0); drain();
      rand_ck = 1'b0;

      // reset in the middle of a flush
      row_q = {9'd1, INV, INV, INV, 9'd6};
      send_row(5, 1'b0);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_disp_hole", int'(disp_hole), 0);
      chk("midrst_valid", int'(valid_final_hole), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      exp_q.delete();
      m_col = 0; m_holes = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      row_q = {9'd2, 9'd2};
      send_row(2, 1'b0); drain();

      // randomized rows
      rand_ck = 1'b1;
      for (int r = 0; r < 40; r++) begin
         enable = ($urandom_range(0, 4) != 0);
         w = $urandom_range(1, 12);
         row_q.delete();
         for (int i = 0; i < w; i++) begin
            if ($urandom_range(0, 9) < 4)      row_q.push_back(INV);
            else if ($urandom_range(0, 1) == 0) row_q.push_back(9'($urandom_range(0, 7)));
            else                                row_q.push_back(9'($urandom_range(0, 510)));
         end
         send_row(w, 1'b1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
